// File: rtl/panda_risc_v_sim_pkg.sv
// Shared definitions for the simulation test device: register offsets,
// STATUS layout and small helpers used to build read data.
package panda_risc_v_sim_pkg;

  localparam logic [3:0] STATUS_OFS  = 4'h0;
  localparam logic [3:0] CONSOLE_OFS = 4'h4;
  localparam logic [3:0] CYC_LO_OFS  = 4'h8;
  localparam logic [3:0] CYC_HI_OFS  = 4'hC;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_PASS_BIT = 1;
  localparam int STATUS_NUM_LSB  = 8;

  typedef struct packed {
    logic [7:0] num;
    logic       pass;
    logic       done;
  } status_t;

  function automatic logic [31:0] status_word(input status_t s);
    logic [31:0] w;
    w = 32'h0;
    w[STATUS_DONE_BIT]       = s.done;
    w[STATUS_PASS_BIT]       = s.pass;
    w[STATUS_NUM_LSB +: 8]   = s.num;
    return w;
  endfunction

  function automatic logic [7:0] sat8(input logic [31:0] v);
    logic [7:0] r;
    if (v > 32'd255) begin
      r = 8'hFF;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/panda_risc_v_sim_byte_fifo.sv
// Synchronous byte FIFO with fall-through read port; a push into a full
// FIFO succeeds only when a pop frees a slot in the same cycle.
module panda_risc_v_sim_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count_r == CW'(0));
  assign full     = (count_r == CW'(DEPTH));
  assign count    = count_r;
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? 8'h00 : mem[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/panda_risc_v_sim_test_dev.sv
// Simulation-only ICB responder: test programs report done/pass/number,
// stream console bytes and read a 64-bit free-running cycle counter.
module panda_risc_v_sim_test_dev
  import panda_risc_v_sim_pkg::*;
#(
  parameter logic [31:0] BASEADDR           = 32'h4000_0000,
  parameter int          CONSOLE_FIFO_DEPTH = 8,
  parameter int          simulation_delay   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_icb_cmd_addr,
  input  logic        s_icb_cmd_read,
  input  logic [31:0] s_icb_cmd_wdata,
  input  logic [3:0]  s_icb_cmd_wmask,
  input  logic        s_icb_cmd_valid,
  output logic        s_icb_cmd_ready,
  output logic [31:0] s_icb_rsp_rdata,
  output logic        s_icb_rsp_err,
  output logic        s_icb_rsp_valid,
  input  logic        s_icb_rsp_ready,
  output logic        test_done,
  output logic        test_pass,
  output logic [7:0]  test_num,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready
);

  localparam int CW = $clog2(CONSOLE_FIFO_DEPTH) + 1;

  if ((CONSOLE_FIFO_DEPTH < 2) || ((CONSOLE_FIFO_DEPTH & (CONSOLE_FIFO_DEPTH - 1)) != 0)
      || (simulation_delay < 0)) begin : g_bad_param
    $error("panda_risc_v_sim_test_dev: illegal parameter value");
  end

  status_t       status_r;
  logic [63:0]   cycle_cnt;
  logic [31:0]   cyc_hi_shadow_r;
  logic          overflow_r;
  logic          rsp_valid_r;
  logic          rsp_err_r;
  logic [31:0]   rsp_rdata_r;

  logic [31:0]   ofs;
  logic [3:0]    reg_ofs;
  logic          decoded;
  logic          accept;
  logic          console_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   rsp_rdata_nxt;
  logic          rsp_err_nxt;
  logic          status_wr;
  logic          console_push;
  logic          cyc_lo_rd;
  logic          unused_ok;

  assign ofs             = s_icb_cmd_addr - BASEADDR;
  assign reg_ofs         = ofs[3:0];
  assign decoded         = (ofs[31:4] == 28'h0) && (s_icb_cmd_addr[1:0] == 2'b00);
  assign s_icb_cmd_ready = ~rsp_valid_r | s_icb_rsp_ready;
  assign accept          = s_icb_cmd_valid & s_icb_cmd_ready;
  assign console_valid   = ~fifo_empty;
  assign console_pop     = console_valid & console_ready;
  assign unused_ok       = &{1'b0, s_icb_cmd_wdata[31:16], s_icb_cmd_wdata[7:2],
                             s_icb_cmd_wmask[3:2]};

  assign s_icb_rsp_valid = rsp_valid_r;
  assign s_icb_rsp_err   = rsp_err_r;
  assign s_icb_rsp_rdata = rsp_rdata_r;
  assign test_done       = status_r.done;
  assign test_pass       = status_r.pass;
  assign test_num        = status_r.num;

  // Address decode: response contents and side-effect strobes for the current command.
  always_comb begin
    rsp_rdata_nxt = 32'h0;
    rsp_err_nxt   = 1'b0;
    status_wr     = 1'b0;
    console_push  = 1'b0;
    cyc_lo_rd     = 1'b0;
    if (!decoded) begin
      rsp_err_nxt = 1'b1;
    end else begin
      case (reg_ofs)
        STATUS_OFS: begin
          if (s_icb_cmd_read) begin
            rsp_rdata_nxt = status_word(status_r);
          end else begin
            status_wr = 1'b1;
          end
        end
        CONSOLE_OFS: begin
          if (s_icb_cmd_read) begin
            rsp_rdata_nxt = {overflow_r, 15'h0, sat8(32'(fifo_count)), 7'h0, fifo_full};
          end else begin
            console_push = s_icb_cmd_wmask[0];
            // A same-cycle pop makes room, so only a truly blocked push is an error.
            rsp_err_nxt  = s_icb_cmd_wmask[0] & fifo_full & ~console_pop;
          end
        end
        CYC_LO_OFS: begin
          if (s_icb_cmd_read) begin
            rsp_rdata_nxt = cycle_cnt[31:0];
            cyc_lo_rd     = 1'b1;
          end else begin
            rsp_err_nxt = 1'b1;
          end
        end
        CYC_HI_OFS: begin
          if (s_icb_cmd_read) begin
            rsp_rdata_nxt = cyc_hi_shadow_r;
          end else begin
            rsp_err_nxt = 1'b1;
          end
        end
        default: rsp_err_nxt = 1'b1;
      endcase
    end
  end

  // Response register: loads on acceptance, holds until the requester takes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0;
    end else if (accept) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= rsp_err_nxt;
      rsp_rdata_r <= rsp_rdata_nxt;
    end else if (s_icb_rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // STATUS fields; frozen once the program has flagged completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_r <= '{num: 8'h00, pass: 1'b0, done: 1'b0};
    end else if (accept && status_wr && !status_r.done) begin
      if (s_icb_cmd_wmask[0]) begin
        status_r.done <= s_icb_cmd_wdata[STATUS_DONE_BIT];
        status_r.pass <= s_icb_cmd_wdata[STATUS_PASS_BIT];
      end
      if (s_icb_cmd_wmask[1]) begin
        status_r.num <= s_icb_cmd_wdata[STATUS_NUM_LSB +: 8];
      end
    end
  end

  // Free-running cycle counter, high-word snapshot and sticky console overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt       <= 64'h0;
      cyc_hi_shadow_r <= 32'h0;
      overflow_r      <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (accept && cyc_lo_rd) begin
        cyc_hi_shadow_r <= cycle_cnt[63:32];
      end
      if (accept && console_push && rsp_err_nxt) begin
        overflow_r <= 1'b1;
      end
    end
  end

  panda_risc_v_sim_byte_fifo #(
    .DEPTH(CONSOLE_FIFO_DEPTH)
  ) u_console_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept & console_push),
    .push_data(s_icb_cmd_wdata[7:0]),
    .pop      (console_pop),
    .pop_data (console_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_panda_risc_v_sim_test_dev.sv
// Self-checking bench: commands push expected responses onto a scoreboard,
// a negedge monitor pops and compares them as responses retire.
module tb_panda_risc_v_sim_test_dev;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_icb_cmd_addr = 32'h0;
  logic        s_icb_cmd_read = 1'b0;
  logic [31:0] s_icb_cmd_wdata = 32'h0;
  logic [3:0]  s_icb_cmd_wmask = 4'h0;
  logic        s_icb_cmd_valid = 1'b0;
  logic        s_icb_cmd_ready;
  logic [31:0] s_icb_rsp_rdata;
  logic        s_icb_rsp_err;
  logic        s_icb_rsp_valid;
  logic        s_icb_rsp_ready = 1'b1;
  logic        test_done;
  logic        test_pass;
  logic [7:0]  test_num;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] con_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tb_cyc = 0;

  panda_risc_v_sim_test_dev #(
    .BASEADDR(BASE), .CONSOLE_FIFO_DEPTH(8), .simulation_delay(1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .test_done(test_done), .test_pass(test_pass), .test_num(test_num),
    .console_data(console_data), .console_valid(console_valid),
    .console_ready(console_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // Response monitor: each retiring response is checked against the oldest expectation.
  always @(negedge clk) begin
    if (resetn && s_icb_rsp_valid && s_icb_rsp_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, none expected", s_icb_rsp_rdata, s_icb_rsp_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ((s_icb_rsp_err !== e.err) || (e.chk && (s_icb_rsp_rdata !== e.rdata))) begin
          n_bad++;
          $display("FAIL rsp: got rdata=%h err=%b, want rdata=%h err=%b (data checked=%b)",
                   s_icb_rsp_rdata, s_icb_rsp_err, e.rdata, e.err, e.chk);
        end
      end
    end
  end

  task automatic send(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                      input logic [3:0] wm, input logic [31:0] erd, input logic eerr,
                      input logic chk);
    exp_t e;
    logic rdy;
    int   cyc;
    e.rdata = erd; e.err = eerr; e.chk = chk;
    sb_q.push_back(e);
    s_icb_cmd_addr  = addr;
    s_icb_cmd_read  = rd;
    s_icb_cmd_wdata = wd;
    s_icb_cmd_wmask = wm;
    s_icb_cmd_valid = 1'b1;
    cyc = 0;
    do begin
      #1;
      rdy = s_icb_cmd_ready;
      @(posedge clk); #1;
      cyc++;
    end while (!rdy && cyc < 50);
    n_cmp++;
    if (!rdy) begin
      n_bad++;
      $display("FAIL cmd_accept: not accepted after %0d cycles, want acceptance", cyc);
    end
  endtask

  task automatic idle();
    s_icb_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL rsp_timeout: %0d responses outstanding, want 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({s_icb_cmd_ready, s_icb_rsp_valid, s_icb_rsp_err, s_icb_rsp_rdata, test_done, test_pass,
         test_num, console_valid, console_data} !== {1'b1, 53'h0}) begin
      n_bad++;
      $display("FAIL reset_values: got ready=%b rv=%b err=%b rdata=%h done=%b pass=%b num=%h cv=%b cd=%h, want ready=1 rest 0",
               s_icb_cmd_ready, s_icb_rsp_valid, s_icb_rsp_err, s_icb_rsp_rdata, test_done,
               test_pass, test_num, console_valid, console_data);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_status();
    s_icb_rsp_ready = 1'b1;
    send(BASE, 1'b0, 32'h0000_0503, 4'b0011, 32'h0, 1'b0, 1'b1);
    idle();
    n_cmp++;
    if ({test_done, test_pass, test_num} !== {1'b1, 1'b1, 8'd5}) begin
      n_bad++;
      $display("FAIL status_outputs: got done=%b pass=%b num=%0d, want 1 1 5", test_done, test_pass, test_num);
    end
    send(BASE, 1'b1, 32'h0, 4'h0, 32'h0000_0503, 1'b0, 1'b1);
    idle();
    wait_drain();
  endtask

  task automatic test_write_once();
    send(BASE, 1'b0, 32'h0000_0901, 4'b0011, 32'h0, 1'b0, 1'b1);
    idle();
    @(posedge clk); #1;
    n_cmp++;
    if ({test_done, test_pass, test_num} !== {1'b1, 1'b1, 8'd5}) begin
      n_bad++;
      $display("FAIL write_once: got done=%b pass=%b num=%0d, want 1 1 5", test_done, test_pass, test_num);
    end
    wait_drain();
  endtask

  task automatic test_console_overflow();
    logic [7:0] b;
    logic [7:0] want;
    console_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'h41 + 8'(i);
      if (i < 8) con_q.push_back(b);
      send(BASE + 32'h4, 1'b0, {24'h0, b}, 4'b0001, 32'h0, (i == 8), 1'b1);
    end
    send(BASE + 32'h4, 1'b1, 32'h0, 4'h0, 32'h8000_0801, 1'b0, 1'b1);
    idle();
    wait_drain();
    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = con_q.pop_front();
      n_cmp++;
      if (console_valid !== 1'b1 || console_data !== want) begin
        n_bad++;
        $display("FAIL console_drain[%0d]: got valid=%b data=%h, want valid=1 data=%h", i, console_valid, console_data, want);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (console_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL console_empty: got valid=%b, want 0", console_valid);
    end
    console_ready = 1'b0;
  endtask

  task automatic test_cycle_snapshot();
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    send(BASE + 32'h8, 1'b1, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    release dut.cycle_cnt;
    send(BASE + 32'hC, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    send(BASE + 32'h8, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    send(BASE + 32'hC, 1'b1, 32'h0, 4'h0, 32'h1, 1'b0, 1'b1);
    idle();
    wait_drain();
  endtask

  task automatic test_backpressure();
    exp_t e;
    s_icb_rsp_ready = 1'b0;
    send(BASE, 1'b1, 32'h0, 4'h0, 32'h0000_0503, 1'b0, 1'b1);
    e.rdata = 32'h8000_0000; e.err = 1'b0; e.chk = 1'b1;
    sb_q.push_back(e);
    s_icb_cmd_addr = BASE + 32'h4; s_icb_cmd_read = 1'b1; s_icb_cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (s_icb_cmd_ready !== 1'b0 || s_icb_rsp_valid !== 1'b1 || s_icb_rsp_rdata !== 32'h0000_0503
          || s_icb_rsp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d]: got ready=%b rv=%b rdata=%h err=%b, want 0 1 00000503 0",
                 i, s_icb_cmd_ready, s_icb_rsp_valid, s_icb_rsp_rdata, s_icb_rsp_err);
      end
      @(posedge clk); #1;
    end
    s_icb_rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (s_icb_cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: got cmd_ready=%b, want 1", s_icb_cmd_ready);
    end
    @(posedge clk); #1;
    idle();
    n_cmp++;
    if (s_icb_rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_accept: got rsp_valid=%b, want 1", s_icb_rsp_valid);
    end
    wait_drain();
  endtask

  task automatic test_errors();
    send(BASE + 32'hC, 1'b0, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1'b1);
    send(BASE + 32'h8, 1'b0, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1'b1);
    send(BASE + 32'h2, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    send(BASE + 32'h5, 1'b0, 32'h0000_0041, 4'h1, 32'h0, 1'b1, 1'b1);
    send(BASE + 32'h10, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    idle();
    wait_drain();
    n_cmp++;
    if (console_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned_push: got console_valid=%b, want 0", console_valid);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = tb_cyc;
    send(BASE, 1'b1, 32'h0, 4'h0, 32'h0000_0503, 1'b0, 1'b1);
    send(BASE + 32'h4, 1'b1, 32'h0, 4'h0, 32'h8000_0000, 1'b0, 1'b1);
    send(BASE, 1'b1, 32'h0, 4'h0, 32'h0000_0503, 1'b0, 1'b1);
    send(BASE + 32'hC, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    idle();
    n_cmp++;
    if (tb_cyc - t0 != 4) begin
      n_bad++;
      $display("FAIL back_to_back_rate: got %0d cycles for 4 commands, want 4", tb_cyc - t0);
    end
    wait_drain();
  endtask

  task automatic test_reset_midresp();
    send(BASE + 32'h4, 1'b0, 32'h0000_005A, 4'h1, 32'h0, 1'b0, 1'b1);
    idle();
    wait_drain();
    s_icb_rsp_ready = 1'b0;
    send(BASE, 1'b1, 32'h0, 4'h0, 32'h0000_0503, 1'b0, 1'b1);
    idle();
    n_cmp++;
    if (s_icb_rsp_valid !== 1'b1 || console_valid !== 1'b1 || test_done !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_state: got rv=%b cv=%b done=%b, want 1 1 1", s_icb_rsp_valid, console_valid, test_done);
    end
    #2;
    resetn = 1'b0;
    #1;
    sb_q.delete();
    n_cmp++;
    if ({s_icb_cmd_ready, s_icb_rsp_valid, s_icb_rsp_err, s_icb_rsp_rdata, test_done, test_pass,
         test_num, console_valid, console_data} !== {1'b1, 53'h0}) begin
      n_bad++;
      $display("FAIL async_reset: got ready=%b rv=%b err=%b rdata=%h done=%b pass=%b num=%h cv=%b cd=%h, want ready=1 rest 0",
               s_icb_cmd_ready, s_icb_rsp_valid, s_icb_rsp_err, s_icb_rsp_rdata, test_done,
               test_pass, test_num, console_valid, console_data);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    s_icb_rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_status();
    test_write_once();
    test_console_overflow();
    test_cycle_snapshot();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_reset_midresp();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
